// File: rtl/sigma_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_lsu_if
//  Description : Bundle of EX request, data-memory bus and writeback response
//                signals around the SigmaCore load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sigma_lsu_if;
  // EX stage request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  // data-memory bus
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  // writeback response
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_wb;
  logic        rsp_misaligned;
  logic        rsp_bus_err;

  // LSU side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_rdata, rsp_rd, rsp_wb, rsp_misaligned, rsp_bus_err
  );

  // EX stage / memory / writeback side
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_rdata, rsp_rd, rsp_wb, rsp_misaligned, rsp_bus_err
  );
endinterface
`default_nettype wire

// File: rtl/sigma_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : sigma_lsu
//  Description : Load/store unit. One request/grant/response bus transaction
//                per op with byte-lane steering, load extension, misalignment
//                trapping and a WAIT-state timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module sigma_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sigma_lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       rsp_rdata_q;
  logic [4:0]        rsp_rd_q;
  logic              rsp_wb_q;
  logic              rsp_mis_q;
  logic              rsp_err_q;

  logic              w_illegal;
  logic              w_accept;
  logic              w_fin_ok;
  logic              w_fin_err;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_shifted;
  logic [31:0]       w_ext;
  logic              w_in_req;

  // Decode the incoming op for alignment faults and unsupported funct3 codes.
  always_comb begin
    w_illegal = 1'b1;
    case (bus.req_funct3)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = bus.req_addr[0];
      3'b010:  w_illegal = |bus.req_addr[1:0];
      3'b100:  w_illegal = bus.req_we;
      3'b101:  w_illegal = bus.req_we | bus.req_addr[0];
      default: w_illegal = 1'b1;
    endcase
  end

  // Byte-lane enables and lane-replicated store data for the latched op.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr_q[1:0];
        w_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << addr_q[1:0];
        w_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata_q;
      end
    endcase
  end

  // Move the addressed lane to bit 0 and sign/zero extend it.
  always_comb begin
    w_shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    w_ext     = bus.mem_rdata;
    case (funct3_q)
      3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_ext = {24'h0, w_shifted[7:0]};
      3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_ext = {16'h0, w_shifted[15:0]};
      default: w_ext = bus.mem_rdata;
    endcase
  end

  // Next-state logic, WAIT timeout counter and completion strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_accept  = 1'b0;
    w_fin_ok  = 1'b0;
    w_fin_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          state_d  = w_illegal ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A response arriving on the last allowed cycle still wins.
        if (bus.mem_rvalid) begin
          state_d  = S_RESP;
          w_fin_ok = 1'b1;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d   = S_RESP;
          w_fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers; reset abandons any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the op on accept and build the response record on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_wb_q    <= 1'b0;
      rsp_mis_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (w_accept) begin
        we_q      <= bus.req_we;
        funct3_q  <= bus.req_funct3;
        addr_q    <= bus.req_addr;
        wdata_q   <= bus.req_wdata;
        rd_q      <= bus.req_rd;
        rsp_mis_q <= w_illegal;
        rsp_err_q <= 1'b0;
        if (w_illegal) begin
          rsp_rdata_q <= '0;
          rsp_rd_q    <= bus.req_rd;
          rsp_wb_q    <= 1'b0;
        end
      end
      if (w_fin_ok) begin
        rsp_rdata_q <= we_q ? 32'h0 : w_ext;
        rsp_rd_q    <= rd_q;
        rsp_wb_q    <= ~we_q & (rd_q != 5'd0);
      end
      if (w_fin_err) begin
        rsp_rdata_q <= '0;
        rsp_rd_q    <= rd_q;
        rsp_wb_q    <= 1'b0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  // Bus fields are only driven while the request is outstanding.
  assign w_in_req           = (state_q == S_REQ);
  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.mem_req        = w_in_req;
  assign bus.mem_we         = w_in_req & we_q;
  assign bus.mem_addr       = w_in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_be         = w_in_req ? w_be : 4'b0000;
  assign bus.mem_wdata      = w_in_req ? w_wdata : 32'h0;
  assign bus.rsp_valid      = (state_q == S_RESP);
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_rd         = rsp_rd_q;
  assign bus.rsp_wb         = rsp_wb_q;
  assign bus.rsp_misaligned = rsp_mis_q;
  assign bus.rsp_bus_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sigma_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sigma_lsu
//  Description : Self-checking bench for sigma_lsu with a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sigma_lsu;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wb;
    logic        mis;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  // observations gathered by run_op
  int          obs_lat;
  int          obs_req_cyc;
  bit          obs_req_seen;
  bit          obs_stable;
  logic        obs_ready;
  logic        obs_extra;
  logic [1:0]  obs_flags_mid;
  logic        obs_we;
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;
  exp_t        obs_rsp;

  sigma_lsu_if bus ();

  sigma_lsu #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent load-extension model built from byte lanes.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0] b [4];
    logic [7:0] lo;
    logic [7:0] hi;
    b[0] = d[7:0];  b[1] = d[15:8];  b[2] = d[23:16];  b[3] = d[31:24];
    lo = b[off];
    hi = b[off | 2'b01];
    case (f3)
      3'b000:  return {{24{lo[7]}}, lo};
      3'b100:  return {24'h0, lo};
      3'b001:  return {{16{hi[7]}}, hi, lo};
      3'b101:  return {16'h0, hi, lo};
      default: return d;
    endcase
  endfunction

  // Drives one op from an IDLE cycle and plays the memory side.
  // rv_dly: WAIT cycle number carrying rvalid (-1 = never respond).
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rdat);
    int req_cyc;
    int wait_cyc;
    bit granted;
    @(negedge clk);
    obs_ready          = bus.req_ready;
    obs_extra          = bus.rsp_valid;
    bus.req_valid      = 1'b1;
    bus.req_we         = we;
    bus.req_funct3     = f3;
    bus.req_addr       = addr;
    bus.req_wdata      = wd;
    bus.req_rd         = rd;
    obs_lat            = -1;
    obs_req_seen       = 0;
    obs_stable         = 1;
    obs_rsp            = '0;
    req_cyc            = 0;
    wait_cyc           = 0;
    granted            = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.req_addr   = $urandom();
      bus.req_wdata  = $urandom();
      bus.req_funct3 = 3'($urandom_range(0, 7));
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'hA5A5_A5A5;
      if (cyc == 1) obs_flags_mid = {bus.rsp_misaligned, bus.rsp_bus_err};
      if (bus.rsp_valid) begin
        obs_lat = cyc;
        obs_rsp = '{bus.rsp_rdata, bus.rsp_rd, bus.rsp_wb, bus.rsp_misaligned, bus.rsp_bus_err};
        break;
      end
      if (bus.mem_req) begin
        if (!obs_req_seen) begin
          obs_req_seen = 1;
          obs_we    = bus.mem_we;
          obs_addr  = bus.mem_addr;
          obs_be    = bus.mem_be;
          obs_wdata = bus.mem_wdata;
        end else if ({bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}
                     !== {obs_we, obs_addr, obs_be, obs_wdata}) begin
          obs_stable = 0;
        end
        req_cyc++;
        if (req_cyc == gnt_dly + 1) begin
          bus.mem_gnt = 1'b1;
          granted     = 1;
        end
      end else if (granted) begin
        wait_cyc++;
        if (wait_cyc == rv_dly) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rdat;
        end
      end
    end
    obs_req_cyc = req_cyc;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
         bus.rsp_valid, bus.rsp_rdata, bus.rsp_rd, bus.rsp_wb, bus.rsp_misaligned, bus.rsp_bus_err}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b req=%b be=%h rsp_valid=%b rdata=%h, required ready=1 others 0",
               bus.req_ready, bus.mem_req, bus.mem_be, bus.rsp_valid, bus.rsp_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after_release: got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_lw();
    exp_t e;
    sb_q.push_back('{32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 1'b0});
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 1, 32'hDEAD_BEEF);
    checks++;
    if ({obs_req_seen, obs_we, obs_addr, obs_be} !== {1'b1, 1'b0, 32'h100, 4'b1111}) begin
      failures++;
      $display("FAIL lw_bus: seen=%b we=%b addr=%h be=%b required 1 0 00000100 1111",
               obs_req_seen, obs_we, obs_addr, obs_be);
    end
    checks++;
    if (obs_lat !== 3) begin
      failures++;
      $display("FAIL lw_latency: got %0d required 3", obs_lat);
    end
    e = sb_q.pop_front();
    checks++;
    if (obs_rsp !== e) begin
      failures++;
      $display("FAIL lw_rsp: got %h required %h", obs_rsp, e);
    end
  endtask

  task automatic test_sub_loads();
    logic [2:0]  f3s  [3] = '{3'b000, 3'b100, 3'b101};
    logic [31:0] adrs [3] = '{32'h103, 32'h103, 32'h102};
    logic [3:0]  bes  [3] = '{4'b1000, 4'b1000, 4'b1100};
    logic [31:0] vals [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
    logic [4:0]  rds  [3] = '{5'd7, 5'd0, 5'd9};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{vals[i], rds[i], (rds[i] != 5'd0), 1'b0, 1'b0});
      run_op(1'b0, f3s[i], adrs[i], 32'h0, rds[i], 0, 1, 32'h80FF_7F01);
      checks++;
      if (obs_be !== bes[i]) begin
        failures++;
        $display("FAIL subload_be[%0d]: got %b required %b", i, obs_be, bes[i]);
      end
      checks++;
      if (obs_lat !== 3) begin
        failures++;
        $display("FAIL subload_latency[%0d]: got %0d required 3", i, obs_lat);
      end
      e = sb_q.pop_front();
      checks++;
      if (obs_rsp !== e) begin
        failures++;
        $display("FAIL subload_rsp[%0d]: got %h required %h", i, obs_rsp, e);
      end
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s  [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] adrs [3] = '{32'h206, 32'h201, 32'h208};
    logic [31:0] wds  [3] = '{32'h1234_ABCD, 32'h0000_005A, 32'hCAFE_BABE};
    logic [31:0] madr [3] = '{32'h204, 32'h200, 32'h208};
    logic [3:0]  bes  [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] mwd  [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'hCAFE_BABE};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{32'h0, 5'd3, 1'b0, 1'b0, 1'b0});
      run_op(1'b1, f3s[i], adrs[i], wds[i], 5'd3, 0, 1, 32'h7777_7777);
      checks++;
      if ({obs_we, obs_addr, obs_be, obs_wdata} !== {1'b1, madr[i], bes[i], mwd[i]}) begin
        failures++;
        $display("FAIL store_bus[%0d]: we=%b addr=%h be=%b wdata=%h required 1 %h %b %h",
                 i, obs_we, obs_addr, obs_be, obs_wdata, madr[i], bes[i], mwd[i]);
      end
      checks++;
      if (obs_lat !== 3) begin
        failures++;
        $display("FAIL store_latency[%0d]: got %0d required 3", i, obs_lat);
      end
      e = sb_q.pop_front();
      checks++;
      if (obs_rsp !== e) begin
        failures++;
        $display("FAIL store_rsp[%0d]: got %h required %h", i, obs_rsp, e);
      end
    end
  endtask

  task automatic test_misaligned();
    logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b001};
    logic [31:0] adrs [5] = '{32'h101, 32'h003, 32'h000, 32'h010, 32'h105};
    logic [4:0]  rds  [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{32'h0, rds[i], 1'b0, 1'b1, 1'b0});
      run_op(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, rds[i], 0, 1, 32'h1111_1111);
      checks++;
      if (obs_req_seen !== 1'b0) begin
        failures++;
        $display("FAIL misaligned_no_bus[%0d]: mem_req seen=%b required 0", i, obs_req_seen);
      end
      checks++;
      if (obs_lat !== 1) begin
        failures++;
        $display("FAIL misaligned_latency[%0d]: got %0d required 1", i, obs_lat);
      end
      e = sb_q.pop_front();
      checks++;
      if (obs_rsp !== e) begin
        failures++;
        $display("FAIL misaligned_rsp[%0d]: got %h required %h", i, obs_rsp, e);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb_q.push_back('{32'h0, 5'd8, 1'b0, 1'b0, 1'b1});
    run_op(1'b0, 3'b010, 32'h40, 32'h0, 5'd8, 0, -1, 32'h0);
    checks++;
    if (obs_lat !== 6) begin
      failures++;
      $display("FAIL timeout_latency: got %0d required 6", obs_lat);
    end
    e = sb_q.pop_front();
    checks++;
    if (obs_rsp !== e) begin
      failures++;
      $display("FAIL timeout_rsp: got %h required %h", obs_rsp, e);
    end
    sb_q.push_back('{32'h1122_3344, 5'd8, 1'b1, 1'b0, 1'b0});
    run_op(1'b0, 3'b010, 32'h44, 32'h0, 5'd8, 0, 4, 32'h1122_3344);
    checks++;
    if (obs_flags_mid !== 2'b00) begin
      failures++;
      $display("FAIL flags_cleared_on_accept: got %b required 00", obs_flags_mid);
    end
    checks++;
    if (obs_lat !== 6) begin
      failures++;
      $display("FAIL late_rvalid_latency: got %0d required 6", obs_lat);
    end
    e = sb_q.pop_front();
    checks++;
    if (obs_rsp !== e) begin
      failures++;
      $display("FAIL late_rvalid_rsp: got %h required %h", obs_rsp, e);
    end
  endtask

  task automatic test_gnt_delay();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        sb_q.push_back('{32'h0BAD_F00D, 5'd10, 1'b1, 1'b0, 1'b0});
        run_op(1'b0, 3'b010, 32'h500, 32'h0, 5'd10, 3, 1, 32'h0BAD_F00D);
      end else begin
        sb_q.push_back('{32'h0, 5'd11, 1'b0, 1'b0, 1'b0});
        run_op(1'b1, 3'b001, 32'h502, 32'h0000_BEEF, 5'd11, 3, 1, 32'h0);
      end
      checks++;
      if (obs_stable !== 1'b1 || obs_req_cyc !== 4) begin
        failures++;
        $display("FAIL gnt_delay_hold[%0d]: stable=%b req_cycles=%0d required 1 and 4",
                 i, obs_stable, obs_req_cyc);
      end
      checks++;
      if (obs_lat !== 6) begin
        failures++;
        $display("FAIL gnt_delay_latency[%0d]: got %0d required 6", i, obs_lat);
      end
      e = sb_q.pop_front();
      checks++;
      if (obs_rsp !== e) begin
        failures++;
        $display("FAIL gnt_delay_rsp[%0d]: got %h required %h", i, obs_rsp, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   seen;
    exp_t e;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h300;
    bus.req_rd     = 5'd4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_req_phase: mem_req got %b required 1", bus.mem_req);
    end
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.mem_req, bus.rsp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL rstmid_immediate: ready/req/rsp_valid got %b required 100",
               {bus.req_ready, bus.mem_req, bus.rsp_valid});
    end
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_rsp: rsp_valid seen=%b required 0", seen);
    end
    sb_q.push_back('{32'hCAFE_F00D, 5'd4, 1'b1, 1'b0, 1'b0});
    run_op(1'b0, 3'b010, 32'h304, 32'h0, 5'd4, 0, 1, 32'hCAFE_F00D);
    checks++;
    if (obs_lat !== 3) begin
      failures++;
      $display("FAIL rstmid_after_latency: got %0d required 3", obs_lat);
    end
    e = sb_q.pop_front();
    checks++;
    if (obs_rsp !== e) begin
      failures++;
      $display("FAIL rstmid_after_rsp: got %h required %h", obs_rsp, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  pick [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f3   [6];
    logic [31:0] adr  [6];
    logic [31:0] dat  [6];
    logic [4:0]  rd   [6];
    logic [31:0] base;
    logic [1:0]  off;
    exp_t        e;
    for (int i = 0; i < 6; i++) begin
      f3[i] = pick[$urandom_range(0, 4)];
      case (f3[i][1:0])
        2'b00:   off = 2'($urandom_range(0, 3));
        2'b01:   off = 2'($urandom_range(0, 1) * 2);
        default: off = 2'b00;
      endcase
      base   = $urandom();
      adr[i] = {base[31:2], off};
      dat[i] = $urandom();
      rd[i]  = 5'($urandom_range(0, 31));
      sb_q.push_back('{ref_load(f3[i], off, dat[i]), rd[i], (rd[i] != 5'd0), 1'b0, 1'b0});
    end
    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, f3[i], adr[i], 32'h0, rd[i], 0, 1, dat[i]);
      checks++;
      if (obs_ready !== 1'b1 || obs_extra !== 1'b0) begin
        failures++;
        $display("FAIL b2b_idle_after_resp[%0d]: ready=%b rsp_valid=%b required 1 0",
                 i, obs_ready, obs_extra);
      end
      checks++;
      if (obs_lat !== 3) begin
        failures++;
        $display("FAIL b2b_latency[%0d]: got %0d required 3", i, obs_lat);
      end
      e = sb_q.pop_front();
      checks++;
      if (obs_rsp !== e) begin
        failures++;
        $display("FAIL b2b_rsp[%0d]: got %h required %h", i, obs_rsp, e);
      end
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_rd     = 5'd0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    test_reset();
    test_lw();
    test_sub_loads();
    test_store();
    test_misaligned();
    test_timeout();
    test_gnt_delay();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sigma_lsu.md
Name: sigma_lsu

Overview:
- Load/store unit directly downstream of the ALU in the SigmaCore execute stage.
- Takes the ALU result (ADD of rs1 + imm) as the effective address, together with the store data and the RISC-V funct3.
- Runs one request/grant/response transaction on the data-memory bus: byte-lane steering, sign/zero extension, misalignment trapping, bus timeout.
- Returns load data and destination register to writeback.

Parameters:
- TIMEOUT_CYCLES, 255: max WAIT-state cycles before bus-error response; 0 disables timeout.
- CNT_W, 8: width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX stage presents a memory op
- req_ready  out  1  LSU accepts op (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  effective address from ALU result
- req_wdata  in  32  rs2 value for stores
- req_rd  in  5  load destination register
- mem_req  out  1  bus request, held until grant
- mem_we  out  1  bus write enable
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  bus grant
- mem_rvalid  in  1  bus response (read data or store ack)
- mem_rdata  in  32  read data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data (0 for stores/errors)
- rsp_rd  out  5  destination register of completed op
- rsp_wb  out  1  1 if writeback must write rsp_rd (successful load, rd≠0)
- rsp_misaligned  out  1  address misaligned or illegal funct3
- rsp_bus_err  out  1  timeout expired

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1; all other outputs 0; counter 0. Reset mid-transaction abandons the op; mem_req drops immediately and no response is issued.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch we, funct3, addr, wdata, rd. If misaligned/illegal go to RESP with rsp_misaligned=1, no bus cycle; else go to REQ.
- Misaligned/illegal conditions:
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
  - funct3 ∈ {011,110,111}
  - store with funct3 ∈ {100,101}
- REQ: mem_req=1 with stable mem_we/addr/be/wdata. On mem_gnt go to WAIT (same-edge), clear counter.
- WAIT: mem_req=0. mem_rvalid is sampled only in WAIT; memory never returns rvalid in the grant cycle.
  - On mem_rvalid: capture data, go to RESP.
  - Otherwise counter++. When TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1 without rvalid, go to RESP with rsp_bus_err=1.
  - rvalid and timeout on the same cycle: rvalid wins.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_* fields stay stable until the next RESP overwrites them; the flags are cleared at the next accept.
- Byte-lane rules (o=addr[1:0]):
  - Byte: be=0001<<o; wdata={4{wdata[7:0]}}.
  - Half: be=0011<<o; wdata={2{wdata[15:0]}}.
  - Word: be=1111.
  - Loads drive the same be with mem_we=0.
- Load extract: shifted=rdata>>(8*o).
  - LB: sign-extend shifted[7:0]. LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0]. LHU: zero-extend shifted[15:0].
  - LW: rdata.
- rsp_wb=1 only for a load with no error and rd≠0.
- Stores: rsp_rdata=0, rsp_wb=0; completion on store ack rvalid.
- Latency, zero-wait bus (accept at edge T, gnt first REQ cycle, rvalid next cycle): rsp_valid high in cycle T+3. Misaligned: rsp_valid at T+1.
- Back-to-back: next req accepted the cycle after RESP; throughput 1 op per 4 cycles minimum.

Test Plan:
- LW addr=0x100, rdata=0xDEADBEEF, rd=5, gnt immediate, rvalid next cycle -> mem_addr=0x100, be=1111, rsp_valid 3 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_rd=5, rsp_wb=1.
- LB addr=0x103, rdata=0x80FF7F01 -> be=1000, rsp_rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x000080FF.
- SH addr=0x206, wdata=0x1234ABCD -> mem_we=1, mem_addr=0x204, be=1100, mem_wdata=0xABCDABCD; ack -> rsp_valid=1, rsp_wb=0.
- LW addr=0x101 and SH addr=0x3 -> no mem_req, rsp_valid next cycle, rsp_misaligned=1, rsp_wb=0; funct3=011 -> same.
- TIMEOUT_CYCLES=4, grant then no rvalid -> rsp_bus_err=1 after 4 WAIT cycles; repeat with rvalid on 4th WAIT cycle -> normal response, bus_err=0.
- Gnt delayed 3 cycles -> mem_req and its fields stable throughout; rst_n pulsed low during WAIT -> mem_req=0, req_ready=1 immediately, no rsp_valid; a following LW completes normally.
